// File: rtl/elastic_buffer_chain.sv
// elastic_buffer_chain: DEPTH-stage valid/data register chain with bubble collapse and optional occupancy level.
// Ports: clk, rst_n (async active-low), flush (sync discard);
//   upstream   data_in/ready_in (payload valid) -> done_in (accepted);
//   downstream data_out/ready_out (payload valid) <- done_out (accepted);
//   level: number of held entries, present only with ELASTIC_BUFFER_CHAIN_LEVEL_EN defined, else tied to 0.
module elastic_buffer_chain #(
  parameter int DATA_BITWIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEVEL_BITWIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [DATA_BITWIDTH-1:0]  data_in,
  input  logic                      ready_in,
  output logic                      done_in,
  output logic [DATA_BITWIDTH-1:0]  data_out,
  output logic                      ready_out,
  input  logic                      done_out,
  output logic [LEVEL_BITWIDTH-1:0] level
);
  logic [DEPTH-1:0] v;
  logic [DATA_BITWIDTH-1:0] d [DEPTH];
  // sv/sd[k] is what stage k sees from its source (index 0 is the upstream port,
  // index DEPTH is the last stage seen by the downstream port); rdy[k] is stage k's
  // load enable, rippling back from done_out so a stalled tail stalls only full stages.
  logic [DEPTH:0] sv, rdy;
  logic [DATA_BITWIDTH-1:0] sd [DEPTH+1];
  assign sv = {v, ready_in};
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = done_out;
    sd[0] = data_in;
    for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = !v[k] || rdy[k+1];
    for (int k = 0; k < DEPTH; k++) sd[k+1] = d[k];
  end
  assign done_in = rdy[0] && !flush && rst_n;
  assign ready_out = sv[DEPTH] && !flush;
  assign data_out = sd[DEPTH];
  // Data registers load only when a valid payload actually moves in, so an idle
  // chain keeps data_out stable.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v[k] <= flush ? 1'b0 : rdy[k] ? sv[k] : v[k];
        if (!flush && rdy[k] && sv[k]) d[k] <= sd[k];
      end
    end
`ifdef ELASTIC_BUFFER_CHAIN_LEVEL_EN
  logic in_x, out_x;
  assign in_x = done_in && ready_in;
  assign out_x = ready_out && done_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) level <= '0;
    else level <= flush ? '0 : level + LEVEL_BITWIDTH'(in_x) - LEVEL_BITWIDTH'(out_x);
`else
  assign level = '0;
`endif
endmodule

// File: tb/tb_elastic_buffer_chain.sv
// tb_elastic_buffer_chain: randomized and directed bench against a queue-based model of the chain.
module tb_elastic_buffer_chain;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int LW = 5;
`ifdef ELASTIC_BUFFER_CHAIN_LEVEL_EN
  localparam bit LV = 1'b1;
`else
  localparam bit LV = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ready_in = 1'b0, done_out = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic done_in, ready_out;
  logic [DW-1:0] data_out;
  logic [LW-1:0] level;
  int checks = 0, failures = 0;

  elastic_buffer_chain #(.DATA_BITWIDTH(DW), .DEPTH(DEPTH), .LEVEL_BITWIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in), .ready_in(ready_in),
    .done_in(done_in), .data_out(data_out), .ready_out(ready_out), .done_out(done_out),
    .level(level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: ordered queue of held items, each with a position 0..DEPTH-1 measured
  // from the input end. Each cycle an item advances unless the slot ahead is still
  // taken after the item ahead of it has moved; the head leaves from DEPTH-1 when
  // done_out is high.
  typedef struct {
    logic [DW-1:0] d;
    int pos;
  } ent_t;
  ent_t q[$];
  bit e_ro, e_di;
  int bnd, e_lv;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_ready_out", int'(ready_out), 0);
      chk("rst_done_in", int'(done_in), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_data_out", int'(data_out), 0);
    end else begin
      e_ro = q.size() > 0 && q[0].pos == DEPTH - 1 && !flush;
      e_lv = q.size();
      chk("m_ready_out", int'(ready_out), int'(e_ro));
      if (e_ro) chk("m_data_out", int'(data_out), int'(q[0].d));
      chk("m_level", int'(level), LV ? e_lv : 0);
      bnd = done_out ? DEPTH + 1 : DEPTH;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].pos + 1 < bnd) q[i].pos++;
        bnd = q[i].pos;
      end
      e_di = !flush && bnd > 0;
      chk("m_done_in", int'(done_in), int'(e_di));
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && q[0].pos == DEPTH) void'(q.pop_front());
        if (e_di && ready_in) q.push_back('{d: data_in, pos: 0});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, k, acc, cyc, pin, pout;
    bit seen;
    repeat (2) step();
    rst_n = 1'b1;
    // Constant-flow stream: first output four cycles after first accept.
    ready_in = 1'b1; done_out = 1'b1; data_in = 8'h01;
    #1 chk("s030_done_in_idle", int'(done_in), 1);
    first = -1; k = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      data_in = DW'(n + 1);
      ready_in = n < 8;
      #1;
      if (ready_out && first < 0) begin
        first = n;
        chk("s030_level", int'(level), LV ? 4 : 0);
      end
      if (ready_out) begin
        k++;
        chk("s030_data", int'(data_out), k);
      end
    end
    chk("s030_latency", first, 4);
    chk("s030_count", k, 8);
    // Full with stalled output, then a simultaneous leave/enter.
    done_out = 1'b0; ready_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      data_in = DW'(8'h10 + n);
      step();
    end
    data_in = 8'h14;
    #1;
    chk("s031_done_in_full", int'(done_in), 0);
    chk("s031_level_full", int'(level), LV ? 4 : 0);
    chk("s031_head", int'(data_out), 8'h10);
    step();
    chk("s031_hold", int'(data_out), 8'h10);
    done_out = 1'b1;
    #1 chk("s031_done_in_open", int'(done_in), 1);
    step();
    ready_in = 1'b0;
    #1;
    chk("s031_next", int'(data_out), 8'h11);
    chk("s031_level_same", int'(level), LV ? 4 : 0);
    repeat (8) step();
    // Flush with both sides requesting.
    done_out = 1'b0; ready_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      data_in = DW'(8'h20 + n);
      step();
    end
    ready_in = 1'b0;
    step();
    chk("s032_pre_ready_out", int'(ready_out), 1);
    flush = 1'b1; ready_in = 1'b1; done_out = 1'b1; data_in = 8'h23;
    #1;
    chk("s032_done_in", int'(done_in), 0);
    chk("s032_ready_out", int'(ready_out), 0);
    step();
    flush = 1'b0; ready_in = 1'b0;
    #1 chk("s032_level", int'(level), 0);
    seen = 0;
    repeat (6) begin
      step();
      seen |= ready_out;
    end
    chk("s032_no_emit", int'(seen), 0);
    // Asynchronous reset with two entries held.
    done_out = 1'b0; ready_in = 1'b1;
    data_in = 8'h30; step();
    data_in = 8'h31; step();
    ready_in = 1'b0;
    repeat (2) step();
    chk("s034_pre_level", int'(level), LV ? 2 : 0);
    chk("s034_pre_ready_out", int'(ready_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s034_ready_out", int'(ready_out), 0);
    chk("s034_level", int'(level), 0);
    chk("s034_done_in", int'(done_in), 0);
    repeat (2) step();
    rst_n = 1'b1;
    done_out = 1'b1; ready_in = 1'b1; data_in = 8'h40;
    step();
    ready_in = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (ready_out) begin
        seen = 1;
        chk("s034_first_out", int'(data_out), 8'h40);
      end
    end
    chk("s034_out_seen", int'(seen), 1);
    // Randomized traffic until 1000 items have been accepted.
    acc = 0; cyc = 0;
    pin = 2; pout = 2;
    while (acc < 1000 && cyc < 20000) begin
      step();
      cyc++;
      if (cyc % 200 == 0) begin
        pin = $urandom_range(1, 3);
        pout = $urandom_range(1, 3);
      end
      ready_in = $urandom_range(0, 3) < pin;
      done_out = $urandom_range(0, 3) < pout;
      data_in = DW'($urandom);
      flush = $urandom_range(0, 96) == 0;
      #1;
      if (done_in && ready_in) acc++;
    end
    chk("s033_items", int'(acc >= 1000), 1);
    flush = 1'b0; ready_in = 1'b0; done_out = 1'b1;
    repeat (8) step();
    chk("s033_drained", int'(ready_out), 0);
    chk("s033_level_end", int'(level), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
